// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared op/state encodings and iteration constants for muldiv_seq.
// Revision : 1.0
// ============================================================================
package muldiv_pkg;

    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = $clog2(MD_ITER);

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Brief    : Request/result bundle between Control and the muldiv_seq unit.
// Revision : 1.0
// ============================================================================
interface muldiv_if;
    import muldiv_pkg::*;

    logic        start;
    md_op_e      op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_zero, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Brief    : One shift-add multiply or restoring shift-subtract divide step.
//            Divide datapath present only when MULDIV_DIV_EN is defined.
// Revision : 1.0
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
(
    input  wire logic        i_is_div,
    input  wire logic [31:0] i_acc_hi,
    input  wire logic [31:0] i_acc_lo,
    input  wire logic [31:0] i_opnd,
    output logic      [31:0] o_acc_hi,
    output logic      [31:0] o_acc_lo
);

    // Multiply: {acc_hi, acc_lo} holds partial product over remaining multiplier bits.
    logic [32:0] w_mul_sum;
    assign w_mul_sum = i_acc_lo[0] ? ({1'b0, i_acc_hi} + {1'b0, i_opnd})
                                   : {1'b0, i_acc_hi};

`ifdef MULDIV_DIV_EN
    logic [32:0] w_div_shl;
    logic [32:0] w_div_diff;
    logic        w_div_ok;

    // Remainder < divisor, so the shifted value fits 33 bits and a set bit 32 means borrow.
    assign w_div_shl  = {i_acc_hi, i_acc_lo[31]};
    assign w_div_diff = w_div_shl - {1'b0, i_opnd};
    assign w_div_ok   = ~w_div_diff[32];

    always_comb begin
        if (i_is_div) begin
            o_acc_hi = w_div_ok ? w_div_diff[31:0] : w_div_shl[31:0];
            o_acc_lo = {i_acc_lo[30:0], w_div_ok};
        end else begin
            o_acc_hi = w_mul_sum[32:1];
            o_acc_lo = {w_mul_sum[0], i_acc_lo[31:1]};
        end
    end
`else
    logic w_unused_is_div;
    assign w_unused_is_div = i_is_div;
    assign o_acc_hi        = w_mul_sum[32:1];
    assign o_acc_lo        = {w_mul_sum[0], i_acc_lo[31:1]};
`endif

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Sequential 32x32 MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//            DIV/DIVU supported only when MULDIV_DIV_EN is defined.
// Revision : 1.0
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
(
    input  wire logic Clk,
    input  wire logic reset,
    muldiv_if.slave   bus
);

    localparam logic [MD_CNT_W-1:0] C_LAST_ITER = MD_CNT_W'(MD_ITER - 1);
    localparam logic [MD_CNT_W-1:0] C_CNT_ONE   = MD_CNT_W'(1);

    md_state_e            r_state;
    md_op_e               r_op;
    logic [31:0]          r_a;
    logic [31:0]          r_b;
    logic [31:0]          r_acc_hi;
    logic [31:0]          r_acc_lo;
    logic [31:0]          r_opnd;
    logic [MD_CNT_W-1:0]  r_cnt;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_div_zero;

    logic                 w_start_ok;
    logic                 w_is_div;
    logic                 w_is_signed;
    logic [31:0]          w_mag_a;
    logic [31:0]          w_mag_b;
    logic [31:0]          w_step_hi;
    logic [31:0]          w_step_lo;
    logic [63:0]          w_prod;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;

`ifdef MULDIV_DIV_EN
    assign w_start_ok = bus.start;
    assign w_is_div   = md_is_div(r_op);
`else
    assign w_start_ok = bus.start & ~md_is_div(bus.op);
    assign w_is_div   = 1'b0;
`endif

    assign w_is_signed = md_is_signed(r_op);
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign w_mag_a     = (w_is_signed && r_a[31]) ? -r_a : r_a;
    assign w_mag_b     = (w_is_signed && r_b[31]) ? -r_b : r_b;

    muldiv_step u_step (
        .i_is_div (w_is_div),
        .i_acc_hi (r_acc_hi),
        .i_acc_lo (r_acc_lo),
        .i_opnd   (r_opnd),
        .o_acc_hi (w_step_hi),
        .o_acc_lo (w_step_lo)
    );

    always_comb begin
        w_prod   = r_neg_res ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (w_is_div) begin
            w_res_lo = r_neg_res ? -r_acc_lo : r_acc_lo;
            w_res_hi = r_neg_rem ? -r_acc_hi : r_acc_hi;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_op       <= MD_MULT;
            r_a        <= '0;
            r_b        <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_opnd     <= '0;
            r_cnt      <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_op    <= bus.op;
                        r_a     <= bus.a_in;
                        r_b     <= bus.b_in;
                        r_busy  <= 1'b1;
                        r_state <= ST_PREP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    r_cnt <= '0;
                    if (w_is_div && (r_b == 32'd0)) begin
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_div_zero <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_acc_hi  <= '0;
                        r_acc_lo  <= w_mag_a;
                        r_opnd    <= w_mag_b;
                        r_neg_res <= w_is_signed & (r_a[31] ^ r_b[31]);
                        r_neg_rem <= w_is_signed & r_a[31];
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt + C_CNT_ONE;
                    if (r_cnt == C_LAST_ITER) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Brief    : Self-checking bench for muldiv_seq: cycle model plus directed vectors.
// Revision : 1.0
// ============================================================================
module tb_muldiv_seq;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic Clk = 1'b0;
    logic reset;
    muldiv_if bus();

    muldiv_seq dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;
    int k;
    logic seen;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endfunction

    // Architectural result of one op, from plain integer arithmetic.
    function automatic void model_calc(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] rhi, output logic [31:0] rlo,
                                       output logic rdz);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        rdz = 1'b0;
        p   = 64'd0;
        case (o)
            MD_MULT:  p = 64'(sa * sb);
            MD_MULTU: p = ua * ub;
            MD_DIV: begin
                if (b == 32'd0) rdz = 1'b1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) rdz = 1'b1;
                else p = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        rhi = p[63:32];
        rlo = p[31:0];
    endfunction

    // Timeline model: accepted op keeps busy for 34 cycles (1 for divide-by-zero), then done.
    int          m_left = 0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi, p_lo;
    logic        p_dz;

    always @(posedge Clk) begin
        if (reset) begin
            m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            m_hi = 32'd0; m_lo = 32'd0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_busy = (m_left != 0);
            m_done = (m_left == 0);
            if (m_left == 0) begin
                m_dz = p_dz;
                if (!p_dz) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (bus.start && (DIV_EN || !(bus.op inside {MD_DIV, MD_DIVU}))) begin
                model_calc(bus.op, bus.a_in, bus.b_in, p_hi, p_lo, p_dz);
                m_left = p_dz ? 1 : 34;
                m_busy = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_on) begin
            chk("cyc_busy", 64'(bus.busy), 64'(m_busy));
            chk("cyc_done", 64'(bus.done), 64'(m_done));
            chk("cyc_div_zero", 64'(bus.div_zero), 64'(m_dz));
            chk("cyc_hi", 64'(bus.hi), 64'(m_hi));
            chk("cyc_lo", 64'(bus.lo), 64'(m_lo));
        end
    end

    // exp_lat == 0 means the request must be ignored entirely.
    task automatic run_op(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input string nm);
        int   n;
        logic any;
        @(negedge Clk);
        bus.start = 1'b1; bus.op = o; bus.a_in = a; bus.b_in = b;
        @(negedge Clk);
        bus.start = 1'b0;
        n   = 1;
        any = 1'b0;
        if (exp_lat == 0) begin
            repeat (40) begin
                if (bus.busy || bus.done) any = 1'b1;
                @(negedge Clk);
            end
            chk({nm, "_ignored"}, 64'(any), 64'd0);
        end else begin
            while (!bus.done && n < 60) begin
                @(negedge Clk);
                n++;
            end
            chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
            chk({nm, "_div_zero"}, 64'(bus.div_zero), 64'(edz));
        end
        chk({nm, "_hi"}, 64'(bus.hi), 64'(ehi));
        chk({nm, "_lo"}, 64'(bus.lo), 64'(elo));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = MD_MULT; bus.a_in = 32'd0; bus.b_in = 32'd0;
        repeat (3) @(negedge Clk);
        chk_on = 1'b1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;

        run_op(MD_MULT,  32'hFFFFFFFD, 32'd7,        35, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_m3x7");
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
        run_op(MD_MULTU, 32'h00000022, 32'h80000001, 35, 32'h00000011, 32'h00000022, 1'b0, "preload");
        run_op(MD_DIVU,  32'd100, 32'd0, DIV_EN ? 2 : 0, 32'h11, 32'h22, 1'b1, "divu_by0");
        run_op(MD_DIV,   32'hFFFFFFF9, 32'd2, DIV_EN ? 35 : 0,
               DIV_EN ? 32'hFFFFFFFF : 32'h11, DIV_EN ? 32'hFFFFFFFD : 32'h22, 1'b0, "div_m7_2");
        run_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_EN ? 35 : 0,
               DIV_EN ? 32'h0 : 32'h11, DIV_EN ? 32'h80000000 : 32'h22, 1'b0, "div_ovf");
        run_op(MD_DIVU,  32'd100, 32'd7, DIV_EN ? 35 : 0,
               DIV_EN ? 32'd2 : 32'h11, DIV_EN ? 32'd14 : 32'h22, 1'b0, "divu_100_7");
        run_op(MD_DIV,   32'd7, 32'hFFFFFFFE, DIV_EN ? 35 : 0,
               DIV_EN ? 32'd1 : 32'h11, DIV_EN ? 32'hFFFFFFFD : 32'h22, 1'b0, "div_7_m2");
        run_op(MD_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 35, 32'h0, 32'h1E, 1'b0, "mult_m5xm6");
        run_op(MD_MULT,  32'h80000000, 32'h80000000, 35, 32'h40000000, 32'h0, 1'b0, "mult_min2");

        // Start held high: operand changes while busy are ignored, DONE restarts immediately.
        @(negedge Clk);
        bus.start = 1'b1; bus.op = MD_MULTU; bus.a_in = 32'd3; bus.b_in = 32'd5;
        @(negedge Clk);
        bus.a_in = 32'd4; bus.b_in = 32'd6;
        k = 1;
        while (!bus.done && k < 60) begin @(negedge Clk); k++; end
        chk("b2b_first_latency", 64'(k), 64'd35);
        chk("b2b_first_lo", 64'(bus.lo), 64'd15);
        chk("b2b_first_hi", 64'(bus.hi), 64'd0);
        @(negedge Clk);
        k++;
        chk("b2b_restart_busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        while (!bus.done && k < 100) begin @(negedge Clk); k++; end
        chk("b2b_second_latency", 64'(k), 64'd70);
        chk("b2b_second_lo", 64'(bus.lo), 64'd24);

        // Reset during RUN iteration 10 must discard the partial result.
        @(negedge Clk);
        bus.start = 1'b1; bus.op = MD_MULTU; bus.a_in = 32'h1234; bus.b_in = 32'h5678;
        @(negedge Clk);
        bus.start = 1'b0;
        repeat (11) @(negedge Clk);
        chk("pre_reset_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        chk("mid_reset_busy", 64'(bus.busy), 64'd0);
        chk("mid_reset_hi", 64'(bus.hi), 64'd0);
        chk("mid_reset_lo", 64'(bus.lo), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            if (bus.done || bus.busy) seen = 1'b1;
            @(negedge Clk);
        end
        chk("mid_reset_no_done", 64'(seen), 64'd0);

        run_op(MD_MULTU, 32'h00010000, 32'h00010000, 35, 32'h1, 32'h0, 1'b0, "multu_recover");

        @(negedge Clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
